// File: rtl/engine_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : engine_scheduler
//  Description : Round-robin dispatch of raster coordinates to NUM_ENG engines,
//                in-order result collection, AXI-Stream pixel output.
//                Optional SCHED_PERF_EN adds the frame_cycles counter port.
//  Revision    : 1.0
// ============================================================================
module engine_scheduler #(
    parameter int NUM_ENG = 4,
    parameter int X_SIZE  = 480,
    parameter int Y_SIZE  = 480,
    parameter int COORD_W = 10,
    parameter int RES_W   = 8
) (
    input  logic                       out_stream_aclk,
    input  logic                       axi_reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       frame_done,
`ifdef SCHED_PERF_EN
    output logic [31:0]                frame_cycles,
`endif
    output logic [COORD_W-1:0]         eng_req_x,
    output logic [COORD_W-1:0]         eng_req_y,
    output logic [NUM_ENG-1:0]         eng_req_valid,
    input  logic [NUM_ENG-1:0]         eng_req_ready,
    input  logic [NUM_ENG*RES_W-1:0]   eng_res_data,
    input  logic [NUM_ENG-1:0]         eng_res_valid,
    output logic [NUM_ENG-1:0]         eng_res_ready,
    output logic [RES_W-1:0]           out_stream_tdata,
    output logic                       out_stream_tvalid,
    input  logic                       out_stream_tready,
    output logic                       out_stream_tuser,
    output logic                       out_stream_tlast
);
    localparam int                 c_PTR_W    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(NUM_ENG - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [COORD_W-1:0] c_X_LAST   = COORD_W'(X_SIZE - 1);
    localparam logic [COORD_W-1:0] c_Y_LAST   = COORD_W'(Y_SIZE - 1);
    localparam logic [COORD_W-1:0] c_C_ONE    = COORD_W'(1);
    localparam logic [NUM_ENG-1:0] c_OH_ONE   = NUM_ENG'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]         r_state, w_state_nxt;
    logic [c_PTR_W-1:0] r_d_ptr, r_c_ptr;
    logic [COORD_W-1:0] r_dx, r_dy, r_cx, r_cy;
    logic [RES_W-1:0]   r_tdata;
    logic               r_tvalid, r_tuser, r_tlast, r_last_pix;
    logic [NUM_ENG-1:0] w_d_onehot, w_c_onehot;
    logic [RES_W-1:0]   w_res_sel;
    logic               w_start, w_active, w_req_fire, w_req_last;
    logic               w_out_fire, w_col_en, w_res_fire;

    assign w_d_onehot = c_OH_ONE << r_d_ptr;
    assign w_c_onehot = c_OH_ONE << r_c_ptr;
    assign w_start    = (r_state == c_ST_IDLE) && start;
    assign w_active   = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
    assign w_req_fire = (r_state == c_ST_RUN) && |(eng_req_ready & w_d_onehot);
    assign w_req_last = (r_dx == c_X_LAST) && (r_dy == c_Y_LAST);
    assign w_out_fire = r_tvalid && out_stream_tready;
    // Output register may take a new result in the same cycle it is drained.
    assign w_col_en   = w_active && (!r_tvalid || out_stream_tready);
    assign w_res_fire = w_col_en && |(eng_res_valid & w_c_onehot);

    always_comb begin
        w_res_sel = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (r_c_ptr == c_PTR_W'(k)) begin
                w_res_sel = eng_res_data[k*RES_W +: RES_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_nxt = c_ST_RUN;
            c_ST_RUN:   if (w_req_fire && w_req_last) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_out_fire && r_last_pix) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk) begin
        if (axi_reset) begin
            r_state    <= c_ST_IDLE;
            r_d_ptr    <= '0;
            r_c_ptr    <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tuser    <= 1'b0;
            r_tlast    <= 1'b0;
            r_last_pix <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_d_ptr <= '0;
                r_c_ptr <= '0;
                r_dx    <= '0;
                r_dy    <= '0;
                r_cx    <= '0;
                r_cy    <= '0;
            end else begin
                if (w_req_fire) begin
                    r_d_ptr <= (r_d_ptr == c_PTR_LAST) ? '0 : r_d_ptr + c_PTR_ONE;
                    if (r_dx == c_X_LAST) begin
                        r_dx <= '0;
                        r_dy <= (r_dy == c_Y_LAST) ? '0 : r_dy + c_C_ONE;
                    end else begin
                        r_dx <= r_dx + c_C_ONE;
                    end
                end
                if (w_res_fire) begin
                    r_c_ptr <= (r_c_ptr == c_PTR_LAST) ? '0 : r_c_ptr + c_PTR_ONE;
                    if (r_cx == c_X_LAST) begin
                        r_cx <= '0;
                        r_cy <= (r_cy == c_Y_LAST) ? '0 : r_cy + c_C_ONE;
                    end else begin
                        r_cx <= r_cx + c_C_ONE;
                    end
                end
            end
            if (w_res_fire) begin
                r_tdata    <= w_res_sel;
                r_tvalid   <= 1'b1;
                r_tuser    <= (r_cx == '0) && (r_cy == '0);
                r_tlast    <= (r_cx == c_X_LAST);
                r_last_pix <= (r_cx == c_X_LAST) && (r_cy == c_Y_LAST);
            end else if (w_out_fire) begin
                r_tvalid <= 1'b0;
            end
        end
    end

`ifdef SCHED_PERF_EN
    logic [31:0] r_frame_cycles;

    always_ff @(posedge out_stream_aclk) begin
        if (axi_reset) begin
            r_frame_cycles <= '0;
        end else if (w_start) begin
            r_frame_cycles <= '0;
        end else if (w_active) begin
            r_frame_cycles <= r_frame_cycles + 32'd1;
        end
    end

    assign frame_cycles = r_frame_cycles;
`endif

    assign busy              = (r_state != c_ST_IDLE);
    assign frame_done        = (r_state == c_ST_DONE);
    assign eng_req_x         = r_dx;
    assign eng_req_y         = r_dy;
    assign eng_req_valid     = (r_state == c_ST_RUN) ? w_d_onehot : '0;
    assign eng_res_ready     = w_col_en ? w_c_onehot : '0;
    assign out_stream_tdata  = r_tdata;
    assign out_stream_tvalid = r_tvalid;
    assign out_stream_tuser  = r_tuser;
    assign out_stream_tlast  = r_tlast;

endmodule
`default_nettype wire

// File: tb/tb_engine_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_engine_scheduler
//  Description : Directed bench for engine_scheduler with behavioural engines
//                (per-engine latency FIFOs) and a stream monitor.
//  Revision    : 1.0
// ============================================================================
module tb_engine_scheduler;
    localparam int NE = 4;
    localparam int XS = 8;
    localparam int YS = 4;
    localparam int CW = 10;
    localparam int RW = 8;
    localparam int NPIX = XS * YS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             start;
    logic             busy;
    logic             frame_done;
    logic [CW-1:0]    req_x, req_y;
    logic [NE-1:0]    req_valid;
    logic [NE-1:0]    req_ready;
    logic [NE*RW-1:0] res_data;
    logic [NE-1:0]    res_valid;
    logic [NE-1:0]    res_ready;
    logic [RW-1:0]    tdata;
    logic             tvalid, tready, tuser, tlast;
`ifdef SCHED_PERF_EN
    logic [31:0]      frame_cycles;
`endif

    engine_scheduler #(
        .NUM_ENG(NE), .X_SIZE(XS), .Y_SIZE(YS), .COORD_W(CW), .RES_W(RW)
    ) dut (
        .out_stream_aclk  (clk),
        .axi_reset        (rst),
        .start            (start),
        .busy             (busy),
        .frame_done       (frame_done),
`ifdef SCHED_PERF_EN
        .frame_cycles     (frame_cycles),
`endif
        .eng_req_x        (req_x),
        .eng_req_y        (req_y),
        .eng_req_valid    (req_valid),
        .eng_req_ready    (req_ready),
        .eng_res_data     (res_data),
        .eng_res_valid    (res_valid),
        .eng_res_ready    (res_ready),
        .out_stream_tdata (tdata),
        .out_stream_tvalid(tvalid),
        .out_stream_tready(tready),
        .out_stream_tuser (tuser),
        .out_stream_tlast (tlast)
    );

    // Engine model: each engine returns x+y lat[k] cycles after its request.
    int fv [NE][64];
    int ft [NE][64];
    int hd [NE];
    int tl [NE];
    int lat [NE];
    int cyc = 0;

    // Monitor log
    logic [7:0] bd [512];
    logic       bu [512];
    logic       bl [512];
    int         nb = 0;
    int         lbc = 0;
    int         fd_cnt = 0;
    int         fd_cyc = 0;
    int         stall_viol = 0;
    int         oh_viol = 0;
    int         ncol = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out = '0;

    int total = 0;
    int bad = 0;

    always_comb begin
        res_valid = '0;
        res_data  = '0;
        for (int k = 0; k < NE; k++) begin
            if (hd[k] != tl[k] && ft[k][hd[k] & 63] <= cyc) res_valid[k] = 1'b1;
            res_data[k*RW +: RW] = 8'(fv[k][hd[k] & 63]);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int k = 0; k < NE; k++) begin
                hd[k] <= 0;
                tl[k] <= 0;
            end
            ncol       <= 0;
            prev_stall <= 1'b0;
        end else begin
            for (int k = 0; k < NE; k++) begin
                if (res_valid[k] && res_ready[k]) hd[k] <= hd[k] + 1;
                if (req_valid[k] && req_ready[k]) begin
                    fv[k][tl[k] & 63] <= int'(req_x) + int'(req_y);
                    ft[k][tl[k] & 63] <= cyc + lat[k];
                    tl[k] <= tl[k] + 1;
                end
            end
            if (tvalid && tready) begin
                bd[nb & 511] <= tdata;
                bu[nb & 511] <= tuser;
                bl[nb & 511] <= tlast;
                nb  <= nb + 1;
                lbc <= cyc;
            end
            if (prev_stall && (!tvalid || {tdata, tuser, tlast} != prev_out))
                stall_viol <= stall_viol + 1;
            prev_stall <= tvalid && !tready;
            prev_out   <= {tdata, tuser, tlast};
            if (res_ready != '0 && res_ready != (NE'(1) << (ncol % NE)))
                oh_viol <= oh_viol + 1;
            if (|(res_ready & res_valid)) ncol <= ncol + 1;
            if (frame_done) begin
                fd_cnt <= fd_cnt + 1;
                fd_cyc <= cyc;
            end
        end
    end

    task automatic set_lat(input int base, input int step);
        for (int k = 0; k < NE; k++) lat[k] = base + step * k;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Returns at the negedge of the DONE cycle, or with to=1 after bound cycles.
    task automatic wait_frame(input int bound, input bit rnd, output bit to);
        to = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (frame_done) begin
                to = 1'b0;
                break;
            end
        end
        tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, frame_done, req_valid, res_ready, tvalid, tuser, tlast, tdata, req_x, req_y} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b fd=%b rqv=%b rsr=%b tv=%b tu=%b tl=%b td=%h x=%0d y=%0d required all 0",
                     busy, frame_done, req_valid, res_ready, tvalid, tuser, tlast, tdata, req_x, req_y);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int b0, f0;
        bit to;
        logic [9:0] got, exp;
        set_lat(3, 0);
        b0 = nb; f0 = fd_cnt;
        pulse_start();
        total++;
        if ({busy, req_valid, req_x, req_y} !== {1'b1, 4'b0001, 10'd0, 10'd0}) begin
            bad++;
            $display("FAIL basic_first_req got busy=%b valid=%b x=%0d y=%0d required 1 0001 0 0", busy, req_valid, req_x, req_y);
        end
        wait_frame(400, 1'b0, to);
        total++;
        if (to) begin bad++; $display("FAIL basic_timeout got no frame_done required frame_done"); end
        total++;
        if (nb - b0 !== NPIX) begin bad++; $display("FAIL basic_count got=%0d required=%0d", nb - b0, NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            got = {bd[(b0 + i) & 511], bu[(b0 + i) & 511], bl[(b0 + i) & 511]};
            exp = {8'((i % XS) + (i / XS)), 1'(i == 0), 1'((i % XS) == XS - 1)};
            total++;
            if (got !== exp) begin bad++; $display("FAIL basic_beat%0d got=%h required=%h", i, got, exp); end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got busy=%b required 0", busy); end
        total++;
        if (fd_cnt - f0 !== 1 || fd_cyc !== lbc + 1) begin
            bad++;
            $display("FAIL basic_frame_done got pulses=%0d at=%0d required 1 at=%0d", fd_cnt - f0, fd_cyc, lbc + 1);
        end
    endtask

    task automatic test_latency();
        int b0, o0;
        bit to;
        logic [9:0] got, exp;
        set_lat(2, 5);
        b0 = nb; o0 = oh_viol;
        pulse_start();
        wait_frame(600, 1'b0, to);
        total++;
        if (to || nb - b0 !== NPIX) begin bad++; $display("FAIL latency_count got=%0d timeout=%b required=%0d", nb - b0, to, NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            got = {bd[(b0 + i) & 511], bu[(b0 + i) & 511], bl[(b0 + i) & 511]};
            exp = {8'((i % XS) + (i / XS)), 1'(i == 0), 1'((i % XS) == XS - 1)};
            total++;
            if (got !== exp) begin bad++; $display("FAIL latency_beat%0d got=%h required=%h", i, got, exp); end
        end
        total++;
        if (oh_viol - o0 !== 0) begin bad++; $display("FAIL latency_onehot got violations=%0d required 0", oh_viol - o0); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int b0, s0;
        bit to;
        logic [9:0] got, exp;
        set_lat(2, 5);
        b0 = nb; s0 = stall_viol;
        pulse_start();
        wait_frame(2000, 1'b1, to);
        total++;
        if (to || nb - b0 !== NPIX) begin bad++; $display("FAIL bp_count got=%0d timeout=%b required=%0d", nb - b0, to, NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            got = {bd[(b0 + i) & 511], bu[(b0 + i) & 511], bl[(b0 + i) & 511]};
            exp = {8'((i % XS) + (i / XS)), 1'(i == 0), 1'((i % XS) == XS - 1)};
            total++;
            if (got !== exp) begin bad++; $display("FAIL bp_beat%0d got=%h required=%h", i, got, exp); end
        end
        total++;
        if (stall_viol - s0 !== 0) begin bad++; $display("FAIL bp_stable got violations=%0d required 0", stall_viol - s0); end
        @(negedge clk);
    endtask

    task automatic test_start_during_run();
        int b0, f0, busy_err;
        bit to;
        set_lat(1, 0);
        b0 = nb; f0 = fd_cnt; busy_err = 0; to = 1'b1;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            if (!busy) busy_err++;
            if (frame_done) begin
                to = 1'b0;
                break;
            end
            start = (i == 6);
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (to || busy_err !== 0) begin bad++; $display("FAIL restart_busy got lowcycles=%0d timeout=%b required 0 0", busy_err, to); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL restart_idle got busy=%b required 0", busy); end
        repeat (40) @(negedge clk);
        total++;
        if (nb - b0 !== NPIX || fd_cnt - f0 !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_single got beats=%0d pulses=%0d busy=%b required %0d 1 0", nb - b0, fd_cnt - f0, busy, NPIX);
        end
    endtask

    task automatic test_back_to_back();
        int b0;
        bit to;
        set_lat(1, 0);
        pulse_start();
        wait_frame(400, 1'b0, to);
        b0 = nb;
        pulse_start();
        total++;
        if (to || req_valid !== 4'b0001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart got valid=%b busy=%b timeout=%b required 0001 1 0", req_valid, busy, to);
        end
        wait_frame(400, 1'b0, to);
        total++;
        if (to || nb - b0 !== NPIX || bu[b0 & 511] !== 1'b1 || bd[(b0 + NPIX - 1) & 511] !== 8'd10) begin
            bad++;
            $display("FAIL b2b_frame got beats=%0d tuser0=%b lastdata=%0d required %0d 1 10",
                     nb - b0, bu[b0 & 511], bd[(b0 + NPIX - 1) & 511], NPIX);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int b0, f0;
        bit to;
        logic [9:0] got, exp;
        set_lat(3, 0);
        b0 = nb; to = 1'b1;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (nb - b0 >= 13) begin
                to = 1'b0;
                break;
            end
        end
        f0 = fd_cnt;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (to || {busy, frame_done, req_valid, res_ready, tvalid, tuser, tlast, tdata, req_x, req_y} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got busy=%b rqv=%b rsr=%b tv=%b td=%h x=%0d y=%0d timeout=%b required all 0",
                     busy, req_valid, res_ready, tvalid, tdata, req_x, req_y, to);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (fd_cnt - f0 !== 0) begin bad++; $display("FAIL midreset_no_done got pulses=%0d required 0", fd_cnt - f0); end
        b0 = nb;
        pulse_start();
        wait_frame(400, 1'b0, to);
        total++;
        if (to || nb - b0 !== NPIX) begin bad++; $display("FAIL midreset_count got=%0d timeout=%b required=%0d", nb - b0, to, NPIX); end
        for (int i = 0; i < NPIX; i += 5) begin
            got = {bd[(b0 + i) & 511], bu[(b0 + i) & 511], bl[(b0 + i) & 511]};
            exp = {8'((i % XS) + (i / XS)), 1'(i == 0), 1'((i % XS) == XS - 1)};
            total++;
            if (got !== exp) begin bad++; $display("FAIL midreset_beat%0d got=%h required=%h", i, got, exp); end
        end
        @(negedge clk);
    endtask

`ifdef SCHED_PERF_EN
    task automatic test_perf();
        int cnt;
        bit to;
        set_lat(1, 0);
        cnt = 0; to = 1'b1;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            if (frame_done) begin
                to = 1'b0;
                break;
            end
            if (busy) cnt++;
            @(negedge clk);
        end
        total++;
        if (to || frame_cycles !== 32'(cnt) || cnt < NPIX - 2 || cnt > NPIX + 2) begin
            bad++;
            $display("FAIL perf_cycles got=%0d measured=%0d timeout=%b required measured within 2 of %0d", frame_cycles, cnt, to, NPIX);
        end
        repeat (3) @(negedge clk);
        total++;
        if (frame_cycles !== 32'(cnt)) begin bad++; $display("FAIL perf_hold got=%0d required=%0d", frame_cycles, cnt); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        tready    = 1'b1;
        req_ready = '1;
        set_lat(3, 0);
        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid();
`ifdef SCHED_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/engine_scheduler.md
# engine_scheduler

Frame-level scheduler that shares NUM_ENG fractal iteration engines across one output pixel stream. It walks the X_SIZE × Y_SIZE pixel raster and dispatches each coordinate to the engines in strict round-robin order. It collects results in the same order, so no reorder buffer is needed. It emits the results as an AXI-Stream with tuser = start-of-frame and tlast = end-of-line, feeding the pixel packer and VDMA path in place of a free-running pattern source.

## Interface
Parameters:
- NUM_ENG, 4, number of engines (2–8)
- X_SIZE, 480, pixels per line
- Y_SIZE, 480, lines per frame
- COORD_W, 10, width of x/y coordinates
- RES_W, 8, width of engine result (iteration count / colour index)

Ports:
- out_stream_aclk  in  1  single clock for all logic
- axi_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last pixel handshakes on the stream
- eng_req_x  out  COORD_W  shared request x coordinate
- eng_req_y  out  COORD_W  shared request y coordinate
- eng_req_valid  out  NUM_ENG  one-hot request valid
- eng_req_ready  in  NUM_ENG  engine can accept a request
- eng_res_data  in  NUM_ENG*RES_W  packed results; engine k occupies [k*RES_W +: RES_W]
- eng_res_valid  in  NUM_ENG  result valid per engine
- eng_res_ready  out  NUM_ENG  one-hot result accept
- out_stream_tdata  out  RES_W  pixel result
- out_stream_tvalid  out  1  stream valid
- out_stream_tready  in  1  stream ready
- out_stream_tuser  out  1  high on pixel (0,0) of each frame
- out_stream_tlast  out  1  high on x = X_SIZE-1

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start.
  - RUN → DRAIN when the request for pixel (X_SIZE-1, Y_SIZE-1) handshakes.
  - DRAIN → DONE when that pixel handshakes on the output stream.
  - DONE → IDLE unconditionally (1 cycle). frame_done = (state == DONE).
- start is ignored outside IDLE.
- Dispatch:
  - Pointer d_ptr starts at 0. In RUN, eng_req_valid = one-hot(d_ptr) and eng_req_x/y = dispatch coordinates (dx, dy).
  - On eng_req_valid[d_ptr] & eng_req_ready[d_ptr]: d_ptr advances modulo NUM_ENG; dx increments.
  - dx wraps to 0 at X_SIZE-1 and dy increments.
- Collect:
  - Pointer c_ptr starts at 0. eng_res_ready = one-hot(c_ptr) when the output register is empty or being drained this cycle (tvalid & tready), in RUN or DRAIN.
  - On handshake: load tdata, tuser = (cx==0 && cy==0), tlast = (cx==X_SIZE-1). Then advance c_ptr modulo NUM_ENG and cx/cy with the same wrap rules.
- Valid and ready rules:
  - Valid signals are not gated by ready.
  - Results from engines other than c_ptr wait. Engines must hold eng_res_valid until accepted.
- The output register holds tdata/tuser/tlast stable while tvalid & !tready.
- Order guarantee: pixel n goes to engine n mod NUM_ENG and is read back from the same engine, so stream order equals raster order.

## Timing
- Reset value of every output is 0; d_ptr, c_ptr and all coordinates are 0; state is IDLE.
- Reset mid-frame aborts immediately with no frame_done. Engines share axi_reset and discard in-flight work.
- Request valid rises the cycle after start.
- Result handshake at cycle N gives tvalid at N+1.
- Sustained rate is 1 pixel/cycle when engines and the sink keep up. A simultaneous output drain and result load in the same cycle is allowed and causes no bubble.
- The last-pixel stream handshake at cycle M gives DONE at M+1 (frame_done high) and IDLE at M+2. start at M+2 begins the next frame.

## Configuration
- SCHED_PERF_EN defined:
  - Adds output port frame_cycles (32 bits). It is cleared on start and increments every cycle in RUN/DRAIN.
  - It holds its value from DONE until the next start. Reset value is 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- NUM_ENG=4, X_SIZE=8, Y_SIZE=4, engines return x+y after a fixed 3-cycle latency, tready=1 → 32 beats with tdata = x+y in raster order; tuser only on beat 0; tlast on beats 7,15,23,31; one frame_done pulse 1 cycle after beat 31.
- Engine k latency = 2+5k → output order still raster; no beat lost or duplicated; eng_res_ready is only ever asserted one-hot at c_ptr.
- Pseudo-random tready at 50% → tdata/tuser/tlast stable while stalled; 32 beats total, correct values.
- start pulsed during RUN → ignored; exactly one frame emitted; busy high from start+1 until frame_done+1.
- axi_reset asserted at beat 13, then start → all outputs 0 after reset; new frame begins at (0,0) with tuser on its first beat.
- With SCHED_PERF_EN, all engines 1-cycle latency, tready=1 → frame_cycles equals the measured cycle count, within 2 cycles of 32 for the 8×4 frame.
